alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

Multi-cycle 8-bit multiply controller that borrows the shared ALU and sequences shift-and-add iterations through its ADD function. Sits beside the control unit: on `START` it takes ownership of the ALU operand/select lines via the datapath mux, issues one ADD per set multiplier bit, and returns the low 8 bits of the product with a `DONE` pulse. Waits a programmable number of cycles per ADD to cover ALU settle delay.

## Interface
- `SETTLE_CYCLES`, default 1: cycles the ALU is driven per ADD before `ALU_RESULT` is captured; legal range 1..7.
- `CLK`  in  1  clock, all state on rising edge.
- `RESET_N`  in  1  reset; one clock, reset asynchronous and active-low.
- `START`  in  1  request; sampled only in IDLE.
- `OPA`  in  8  multiplicand, sampled with `START`.
- `OPB`  in  8  multiplier, sampled with `START`.
- `BUSY`  out  1  high while in EXEC.
- `DONE`  out  1  one-cycle pulse, product valid.
- `PRODUCT`  out  8  (OPA*OPB) mod 256; held until next accepted `START`.
- `ZERO`  out  1  `PRODUCT == 0`, updated with `PRODUCT`.
- `ALU_OWN`  out  1  high in EXEC; selects this block onto ALU inputs.
- `ALU_DATA1`  out  8  accumulator operand.
- `ALU_DATA2`  out  8  shifted multiplicand operand.
- `ALU_SELECT`  out  3  001 (ADD) while an ADD is issued, else 000.
- `ALU_RESULT`  in  8  ALU output.

## Operation
- Internal regs: `ACC[7:0]`, `MCAND[7:0]`, `MPLR[7:0]`, `BITCNT[3:0]`, `SETCNT[2:0]`.
- States: IDLE, EXEC, FIN.
- IDLE: `START`=1 → load `MCAND`=`OPA`, `MPLR`=`OPB`, `ACC`=0, `BITCNT`=0, `SETCNT`=0 → EXEC.
- EXEC, `MPLR[0]`=1: drive `ALU_SELECT`=001, `ALU_DATA1`=`ACC`, `ALU_DATA2`=`MCAND`; increment `SETCNT` each cycle. When `SETCNT`=`SETTLE_CYCLES`-1, the edge captures `ACC`←`ALU_RESULT` and advances the bit.
- EXEC, `MPLR[0]`=0: one cycle, `ALU_SELECT`=000, no capture, advance the bit.
- Advancing the bit: `MCAND`←`MCAND`<<1 (bit 7 dropped), `MPLR`←`MPLR`>>1, `BITCNT`+1, `SETCNT`=0. When `BITCNT` reaches 8 → FIN.
- FIN: `PRODUCT`←`ACC`, `DONE`=1 for this cycle, `ALU_OWN`=0 → IDLE.
- All arithmetic is 8-bit and wraps; there is no overflow flag.
- Idle drive: `ALU_DATA1`=`ALU_DATA2`=0, `ALU_SELECT`=000.

## Timing
- Reset values: state IDLE. `BUSY`, `DONE`, `ALU_OWN`=0. `PRODUCT`=0, `ZERO`=1. `ALU_*` outputs 0. Internal regs 0.
- Reset mid-EXEC aborts immediately. No `DONE` is issued and `PRODUCT` returns to 0.
- Latency from the `START` edge to `DONE` high = 8 + popcount(`OPB`)·(`SETTLE_CYCLES`-1) cycles in EXEC, plus 1 cycle in FIN.
- `START` in EXEC or FIN is ignored, not queued. `OPA`/`OPB` changes after acceptance have no effect.
- `START` may be held high: a new operation is accepted in the IDLE cycle after FIN.
- `BUSY` and `ALU_OWN` are registered and rise the cycle after `START` is sampled.

## Configuration
- `MUL_EARLY_EXIT_EN` defined:
  - EXEC → FIN as soon as `MPLR` is 0 after a shift.
  - IDLE with `START` and `OPB`=0 → FIN directly.
  - Latency = (index of the highest set bit of `OPB` + 1) + popcount·(`SETTLE_CYCLES`-1), plus FIN.
- `MUL_EARLY_EXIT_EN` undefined: always 8 bit-steps. The result is identical either way.

## Structure
- Package `alu_ctrl_pkg` holds:
  - the state enum (IDLE/EXEC/FIN);
  - ALU select constants `ALU_SEL_FWD`=000, `ALU_SEL_ADD`=001, `ALU_SEL_AND`=010, `ALU_SEL_OR`=011;
  - data width constant 8.
- One sub-module, `alu_settle_timer`: `SETCNT` counter with load/clear, emitting `SETTLE_LAST`. Parameterised by `SETTLE_CYCLES`.

## Test plan
- Reset, then `OPA`=5, `OPB`=3, `SETTLE_CYCLES`=1 → `PRODUCT`=15, `ZERO`=0. `DONE` 9 cycles after the `START` edge (3 with `MUL_EARLY_EXIT_EN`). `ALU_SELECT`=001 in exactly 2 cycles.
- `OPA`=255, `OPB`=255, `SETTLE_CYCLES`=3 → `PRODUCT`=1. EXEC lasts 8+8·2=24 cycles. `ACC` changes only on settle-last edges.
- `OPA`=16, `OPB`=16 → `PRODUCT`=0, `ZERO`=1. `OPA`=7, `OPB`=0 → `PRODUCT`=0, and with `MUL_EARLY_EXIT_EN` `DONE` arrives 1 cycle after `START`.
- `START` pulsed again mid-EXEC with new operands → ignored. The first result is correct and only one `DONE` pulse is seen.
- Assert `RESET_N`=0 for one cycle in the middle of EXEC → all outputs at reset values, no `DONE`. A fresh `START` of 6*7 then gives 42.
- `START` held high for 3 operations → consecutive results with exactly one IDLE cycle between FIN and the next EXEC.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU control slice: multiply sequencer state
// encoding, ALU function-select codes and the datapath width.
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_FIN  = 2'd2
   } mul_state_t;

   typedef logic [2:0] alu_sel_t;

   localparam alu_sel_t ALU_SEL_FWD = 3'b000;
   localparam alu_sel_t ALU_SEL_ADD = 3'b001;
   localparam alu_sel_t ALU_SEL_AND = 3'b010;
   localparam alu_sel_t ALU_SEL_OR  = 3'b011;

endpackage

// File: rtl/alu_settle_timer.sv
// -----------------------------------------------------------------------------
// alu_settle_timer
// Counts the cycles the shared ALU has been driven with the current ADD so the
// sequencer knows when ALU_RESULT has settled.
//
// Parameters:
//   SETTLE_CYCLES  cycles per ADD (1..7)
// Ports:
//   clk          in   clock
//   reset_n      in   asynchronous active-low reset
//   clr          in   return count to 0 (wins over inc)
//   inc          in   advance count by one
//   settle_last  out  current cycle is the last settle cycle of this ADD
// -----------------------------------------------------------------------------
module alu_settle_timer #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic inc,
   output logic settle_last
);

   logic [2:0] setcnt;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         setcnt <= 3'd0;
      end else if (clr) begin
         setcnt <= 3'd0;
      end else if (inc) begin
         setcnt <= setcnt + 3'd1;
      end
   end

   assign settle_last = (setcnt == 3'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer
// Shift-and-add 8-bit multiplier that borrows the shared ALU. On an accepted
// start it owns the ALU inputs, issues one ADD per set multiplier bit (each
// held for SETTLE_CYCLES cycles before the result is captured), then returns
// (opa*opb) mod 256 with a one-cycle done pulse.
//
// Optional feature: define MUL_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero (result is unchanged).
//
// Parameters:
//   SETTLE_CYCLES  ALU settle cycles per ADD (1..7)
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start          request, sampled only in IDLE
//   opa, opb       multiplicand / multiplier, captured with start
//   busy           high while in EXEC
//   done           one-cycle pulse, product valid
//   product, zero  result and product==0 flag, held until the next result
//   alu_own        selects this block onto the ALU inputs (EXEC only)
//   alu_data1/2    accumulator / shifted multiplicand operands
//   alu_select     ADD while an ADD is issued, else FWD
//   alu_result     ALU output
// -----------------------------------------------------------------------------
module alu_mul_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] opa,
   input  logic [DATA_W-1:0] opb,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product,
   output logic              zero,
   output logic              alu_own,
   output logic [DATA_W-1:0] alu_data1,
   output logic [DATA_W-1:0] alu_data2,
   output alu_sel_t          alu_select,
   input  logic [DATA_W-1:0] alu_result
);

   mul_state_t        state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] mcand_q, mplr_q;
   logic [3:0]        bitcnt_q;

   logic accept, adding, settle_last, advance, capture, last_step, skip_all;

   assign accept  = (state_q == ST_IDLE) && start;
   assign adding  = (state_q == ST_EXEC) && mplr_q[0];
   // A zero multiplier bit takes one cycle; a set bit waits for the ALU.
   assign advance = (state_q == ST_EXEC) && (!mplr_q[0] || settle_last);
   assign capture = adding && settle_last;

`ifdef MUL_EARLY_EXIT_EN
   // Stop once the bits still to be shifted in are all zero.
   assign last_step = (bitcnt_q == 4'd7) || (mplr_q[DATA_W-1:1] == '0);
   assign skip_all  = (opb == '0);
`else
   assign last_step = (bitcnt_q == 4'd7);
   assign skip_all  = 1'b0;
`endif

   alu_settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk         (clk),
      .reset_n     (reset_n),
      .clr         (accept || advance),
      .inc         (adding),
      .settle_last (settle_last)
   );

   // NOTE: every variable assigned in a combinational block gets a default at
   // the top so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               acc_d   = '0;
               state_d = skip_all ? ST_FIN : ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (capture)              acc_d   = alu_result;
            if (advance && last_step) state_d = ST_FIN;
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplr_q   <= '0;
         bitcnt_q <= 4'd0;
         product  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         if (accept) begin
            mcand_q  <= opa;
            mplr_q   <= opb;
            bitcnt_q <= 4'd0;
         end else if (advance) begin
            mcand_q  <= mcand_q << 1;
            mplr_q   <= mplr_q >> 1;
            bitcnt_q <= bitcnt_q + 4'd1;
         end
         // Publish on the edge entering FIN so product is valid with done.
         if (state_d == ST_FIN && state_q != ST_FIN) product <= acc_d;
      end
   end

   assign busy       = (state_q == ST_EXEC);
   assign alu_own    = (state_q == ST_EXEC);
   assign done       = (state_q == ST_FIN);
   assign zero       = (product == '0);
   assign alu_select = adding ? ALU_SEL_ADD : ALU_SEL_FWD;
   assign alu_data1  = adding ? acc_q   : '0;
   assign alu_data2  = adding ? mcand_q : '0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_sequencer
// Two sequencer instances (SETTLE_CYCLES = 1 and 3), each with its own
// behavioural ALU. Directed scenarios with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_alu_mul_sequencer;
   import alu_ctrl_pkg::*;

`ifdef MUL_EARLY_EXIT_EN
   localparam int LAT_5X3   = 3;
   localparam int LAT_16X16 = 6;
   localparam int LAT_7X0   = 1;
   localparam int LAT_6X7   = 4;
`else
   localparam int LAT_5X3   = 9;
   localparam int LAT_16X16 = 9;
   localparam int LAT_7X0   = 9;
   localparam int LAT_6X7   = 9;
`endif
   localparam int LAT_255X255 = 25;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start1, start3;
   logic [7:0] opa, opb;

   logic       busy1, done1, zero1, own1;
   logic [7:0] product1, d1_1, d2_1, res1;
   alu_sel_t   sel1;
   logic       busy3, done3, zero3, own3;
   logic [7:0] product3, d1_3, d2_3, res3;
   alu_sel_t   sel3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_model(input alu_sel_t s, input logic [7:0] a,
                                            input logic [7:0] b);
      case (s)
         ALU_SEL_ADD: return a + b;
         ALU_SEL_AND: return a & b;
         ALU_SEL_OR:  return a | b;
         default:     return a;
      endcase
   endfunction

   assign res1 = alu_model(sel1, d1_1, d2_1);
   assign res3 = alu_model(sel3, d1_3, d2_3);

   alu_mul_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .opa(opa), .opb(opb),
      .busy(busy1), .done(done1), .product(product1), .zero(zero1),
      .alu_own(own1), .alu_data1(d1_1), .alu_data2(d2_1),
      .alu_select(sel1), .alu_result(res1));

   alu_mul_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .start(start3), .opa(opa), .opb(opb),
      .busy(busy3), .done(done3), .product(product3), .zero(zero3),
      .alu_own(own3), .alu_data1(d1_3), .alu_data2(d2_3),
      .alu_select(sel3), .alu_result(res3));

   // Observation mux onto the instance under test.
   logic       use3 = 1'b0;
   logic       m_busy, m_done, m_zero, m_own;
   logic [7:0] m_product, m_d1, m_d2;
   alu_sel_t   m_sel;
   assign m_busy    = use3 ? busy3    : busy1;
   assign m_done    = use3 ? done3    : done1;
   assign m_zero    = use3 ? zero3    : zero1;
   assign m_own     = use3 ? own3     : own1;
   assign m_product = use3 ? product3 : product1;
   assign m_d1      = use3 ? d1_3     : d1_1;
   assign m_d2      = use3 ? d2_3     : d2_1;
   assign m_sel     = use3 ? sel3     : sel1;

   // Runs one operation and reports what was observed. latency counts clock
   // edges from the start-sampling edge (=1) to the edge that raises done.
   // repulse_at > 0 pulses start again with operands 9*9 at that cycle.
   task automatic run_op(input logic u3, input logic [7:0] a, input logic [7:0] b,
                         input int repulse_at, output int latency,
                         output logic [7:0] prod, output logic z,
                         output int busy_cyc, output int add_cyc,
                         output int done_cnt, output int acc_viol);
      int n;
      logic [7:0] pd1, pd2;
      logic pvalid;
      use3 = u3; latency = 0; prod = 8'hxx; z = 1'bx;
      busy_cyc = 0; add_cyc = 0; done_cnt = 0; acc_viol = 0; pvalid = 1'b0;
      pd1 = 8'h00; pd2 = 8'h00;
      @(negedge clk);
      opa = a; opb = b;
      if (u3) start3 = 1'b1; else start1 = 1'b1;
      @(posedge clk); n = 1; #1;
      for (int cyc = 0; cyc < 200; cyc++) begin
         start1 = 1'b0; start3 = 1'b0;
         if (repulse_at != 0 && n == repulse_at) begin
            opa = 8'd9; opb = 8'd9;
            if (u3) start3 = 1'b1; else start1 = 1'b1;
         end
         if (m_busy) busy_cyc++;
         if (m_sel == ALU_SEL_ADD) begin
            add_cyc++;
            // Same operand-2 means same bit: the accumulator must be steady.
            if (pvalid && m_d2 == pd2 && m_d1 != pd1) acc_viol++;
            pd1 = m_d1; pd2 = m_d2; pvalid = 1'b1;
         end
         if (m_done) begin
            done_cnt++;
            if (latency == 0) begin
               latency = n; prod = m_product; z = m_zero;
            end
         end
         if (latency != 0 && n >= latency + 3) break;
         @(posedge clk); n++; #1;
      end
      start1 = 1'b0; start3 = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start1 = 1'b0; start3 = 1'b0; opa = 8'h00; opb = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         use3 = (i == 1); #1;
         checks++;
         if ({m_busy, m_done, m_own} !== 3'b000) begin
            errors++; $display("FAIL reset_flags[%0d]: got %b expected 000", i, {m_busy, m_done, m_own});
         end
         checks++;
         if (m_product !== 8'd0 || m_zero !== 1'b1) begin
            errors++; $display("FAIL reset_product[%0d]: got %0d/%b expected 0/1", i, m_product, m_zero);
         end
         checks++;
         if (m_sel !== ALU_SEL_FWD || m_d1 !== 8'd0 || m_d2 !== 8'd0) begin
            errors++; $display("FAIL reset_alu[%0d]: got sel %b d1 %0h d2 %0h expected 0", i, m_sel, m_d1, m_d2);
         end
      end
   endtask

   task automatic test_basic();
      int lat, bc, ac, dc, av; logic [7:0] p; logic z;
      run_op(1'b0, 8'd5, 8'd3, 0, lat, p, z, bc, ac, dc, av);
      checks++;
      if (p !== 8'd15 || z !== 1'b0) begin
         errors++; $display("FAIL basic_product: got %0d/%b expected 15/0", p, z);
      end
      checks++;
      if (lat !== LAT_5X3) begin
         errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT_5X3);
      end
      checks++;
      if (ac !== 2) begin
         errors++; $display("FAIL basic_add_cycles: got %0d expected 2", ac);
      end
      checks++;
      if (bc !== LAT_5X3 - 1 || dc !== 1) begin
         errors++; $display("FAIL basic_busy_done: got busy %0d done %0d expected %0d/1", bc, dc, LAT_5X3 - 1);
      end
   endtask

   task automatic test_settle();
      int lat, bc, ac, dc, av; logic [7:0] p; logic z;
      run_op(1'b1, 8'd255, 8'd255, 0, lat, p, z, bc, ac, dc, av);
      checks++;
      if (p !== 8'd1 || z !== 1'b0) begin
         errors++; $display("FAIL settle_product: got %0d/%b expected 1/0", p, z);
      end
      checks++;
      if (bc !== 24 || lat !== LAT_255X255) begin
         errors++; $display("FAIL settle_exec_len: got busy %0d lat %0d expected 24/%0d", bc, lat, LAT_255X255);
      end
      checks++;
      if (ac !== 24 || av !== 0) begin
         errors++; $display("FAIL settle_acc_hold: got adds %0d early acc changes %0d expected 24/0", ac, av);
      end
   endtask

   task automatic test_zero();
      int lat, bc, ac, dc, av; logic [7:0] p; logic z;
      run_op(1'b0, 8'd16, 8'd16, 0, lat, p, z, bc, ac, dc, av);
      checks++;
      if (p !== 8'd0 || z !== 1'b1 || lat !== LAT_16X16) begin
         errors++; $display("FAIL zero_wrap: got %0d/%b lat %0d expected 0/1 lat %0d", p, z, lat, LAT_16X16);
      end
      run_op(1'b0, 8'd7, 8'd0, 0, lat, p, z, bc, ac, dc, av);
      checks++;
      if (p !== 8'd0 || z !== 1'b1 || ac !== 0) begin
         errors++; $display("FAIL zero_opb: got %0d/%b adds %0d expected 0/1/0", p, z, ac);
      end
      checks++;
      if (lat !== LAT_7X0 || bc !== LAT_7X0 - 1) begin
         errors++; $display("FAIL zero_opb_latency: got lat %0d busy %0d expected %0d/%0d", lat, bc, LAT_7X0, LAT_7X0 - 1);
      end
   endtask

   task automatic test_ignore_start();
      int lat, bc, ac, dc, av; logic [7:0] p; logic z;
      run_op(1'b0, 8'd5, 8'd3, 2, lat, p, z, bc, ac, dc, av);
      checks++;
      if (p !== 8'd15 || lat !== LAT_5X3) begin
         errors++; $display("FAIL ignore_result: got %0d lat %0d expected 15 lat %0d", p, lat, LAT_5X3);
      end
      checks++;
      if (dc !== 1) begin
         errors++; $display("FAIL ignore_done_count: got %0d expected 1", dc);
      end
   endtask

   task automatic test_reset_mid_exec();
      int lat, bc, ac, dc, av, late_done; logic [7:0] p; logic z;
      use3 = 1'b0;
      @(negedge clk); opa = 8'd200; opb = 8'd3; start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0;
      repeat (3) @(posedge clk);
      #2; reset_n = 1'b0; #1;
      checks++;
      if ({m_busy, m_done, m_own} !== 3'b000 || m_product !== 8'd0 || m_zero !== 1'b1) begin
         errors++; $display("FAIL midreset_outputs: got flags %b product %0d zero %b expected 000/0/1",
                            {m_busy, m_done, m_own}, m_product, m_zero);
      end
      checks++;
      if (m_sel !== ALU_SEL_FWD || m_d1 !== 8'd0 || m_d2 !== 8'd0) begin
         errors++; $display("FAIL midreset_alu: got sel %b d1 %0h d2 %0h expected 0", m_sel, m_d1, m_d2);
      end
      @(posedge clk); @(negedge clk); reset_n = 1'b1;
      late_done = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (m_done || m_busy) late_done++;
      end
      checks++;
      if (late_done !== 0) begin
         errors++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", late_done);
      end
      run_op(1'b0, 8'd6, 8'd7, 0, lat, p, z, bc, ac, dc, av);
      checks++;
      if (p !== 8'd42 || z !== 1'b0 || lat !== LAT_6X7) begin
         errors++; $display("FAIL midreset_fresh: got %0d/%b lat %0d expected 42/0 lat %0d", p, z, lat, LAT_6X7);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ta [3] = '{8'd3, 8'd10, 8'd20};
      logic [7:0] tb [3] = '{8'd5, 8'd10, 8'd13};
      logic [7:0] te [3] = '{8'd15, 8'd100, 8'd4};
      int k, gap;
      k = 0; gap = -1; use3 = 1'b0;
      @(negedge clk); opa = ta[0]; opb = tb[0]; start1 = 1'b1;
      for (int cyc = 0; cyc < 120 && k < 3; cyc++) begin
         @(posedge clk); #1;
         if (m_done) begin
            checks++;
            if (m_product !== te[k]) begin
               errors++; $display("FAIL b2b_product[%0d]: got %0d expected %0d", k, m_product, te[k]);
            end
            k++;
            gap = 0;
            if (k < 3) begin
               opa = ta[k]; opb = tb[k];
            end else begin
               start1 = 1'b0;
            end
         end else if (gap >= 0 && !m_busy) begin
            gap++;
         end else if (gap >= 0 && m_busy) begin
            checks++;
            if (gap !== 1) begin
               errors++; $display("FAIL b2b_idle_gap: got %0d idle cycles expected 1", gap);
            end
            gap = -1;
         end
      end
      start1 = 1'b0;
      checks++;
      if (k !== 3) begin
         errors++; $display("FAIL b2b_count: got %0d results expected 3", k);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_settle();
      test_zero();
      test_ignore_start();
      test_reset_mid_exec();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
